// File: rtl/branch_sequencer_if.sv
// Datapath-side bundle of the Mini SRC branch sequencer: instruction/condition inputs
// and the bus-select / register-load strobes driven by the control unit.
interface branch_sequencer_if;
    logic [31:0] ir;
    logic        con;
    logic        mem_ack;
    logic        PCout, MARin, IncPC, Zin, Zlowout, PCin;
    logic        Read, MDRin, MDRout, IRin;
    logic        Gra, Rout, CONin, Yin, Cout;
    logic        alu_add;

    modport master (
        input  ir, con, mem_ack,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin,
        output Read, MDRin, MDRout, IRin,
        output Gra, Rout, CONin, Yin, Cout, alu_add
    );

    modport slave (
        output ir, con, mem_ack,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin,
        input  Read, MDRin, MDRout, IRin,
        input  Gra, Rout, CONin, Yin, Cout, alu_add
    );
endinterface

// File: rtl/branch_sequencer.sv
// Control-step sequencer for one Mini SRC instruction: fetch (T0-T2) then a
// conditional-branch execute (T3-T6), with memory-wait timeout and taken-branch count.
module branch_sequencer #(
    parameter logic [4:0] OPC_BR      = 5'b10010,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    branch_sequencer_if.master  dp,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                fault,
    output logic [7:0]          taken_cnt
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_DEC, ST_T3, ST_T4,
        ST_T5, ST_T6, ST_DONE, ST_ILL, ST_FAULT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       unused_ir_bits;

    assign unused_ir_bits = ^dp.ir[26:0];

    // The wait counter sits at zero outside T1, so every T1 entry starts a fresh count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            taken_cnt <= '0;
        end else begin
            state <= next_state;
            if (state != ST_T1)
                wait_cnt <= '0;
            else if (!dp.mem_ack)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == ST_T6 && dp.con)
                taken_cnt <= taken_cnt + 8'd1;
        end
    end

    always_comb begin
        next_state = state;
        dp.PCout   = 1'b0;
        dp.MARin   = 1'b0;
        dp.IncPC   = 1'b0;
        dp.Zin     = 1'b0;
        dp.Zlowout = 1'b0;
        dp.PCin    = 1'b0;
        dp.Read    = 1'b0;
        dp.MDRin   = 1'b0;
        dp.MDRout  = 1'b0;
        dp.IRin    = 1'b0;
        dp.Gra     = 1'b0;
        dp.Rout    = 1'b0;
        dp.CONin   = 1'b0;
        dp.Yin     = 1'b0;
        dp.Cout    = 1'b0;
        dp.alu_add = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: if (start) next_state = ST_T0;
            ST_T0: begin
                dp.PCout   = 1'b1;
                dp.MARin   = 1'b1;
                dp.IncPC   = 1'b1;
                dp.Zin     = 1'b1;
                next_state = ST_T1;
            end
            // The incremented PC is written back only once, on the first T1 cycle.
            ST_T1: begin
                dp.Zlowout = (wait_cnt == 8'd0);
                dp.PCin    = (wait_cnt == 8'd0);
                dp.Read    = 1'b1;
                dp.MDRin   = 1'b1;
                if (dp.mem_ack)
                    next_state = ST_T2;
                else if (wait_cnt == TIMEOUT)
                    next_state = ST_FAULT;
            end
            ST_T2: begin
                dp.MDRout  = 1'b1;
                dp.IRin    = 1'b1;
                next_state = ST_DEC;
            end
            ST_DEC: next_state = (dp.ir[31:27] == OPC_BR) ? ST_T3 : ST_ILL;
            ST_T3: begin
                dp.Gra     = 1'b1;
                dp.Rout    = 1'b1;
                dp.CONin   = 1'b1;
                next_state = ST_T4;
            end
            ST_T4: begin
                dp.PCout   = 1'b1;
                dp.Yin     = 1'b1;
                next_state = ST_T5;
            end
            ST_T5: begin
                dp.Cout    = 1'b1;
                dp.alu_add = 1'b1;
                dp.Zin     = 1'b1;
                next_state = ST_T6;
            end
            ST_T6: begin
                dp.Zlowout = 1'b1;
                dp.PCin    = dp.con;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            ST_ILL: begin
                illegal    = 1'b1;
                next_state = ST_IDLE;
            end
            ST_FAULT: begin
                fault      = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle control-step sequencer for the Mini SRC datapath.
- Drives bus-select and register-load strobes for one instruction: fetch (T0–T2) followed by a conditional-branch execute (T3–T6).
- Uses the condition flip-flop's CON output to decide whether the branch target is written to PC.
- Sits between the top-level run/step control and the datapath; one instruction per start pulse.

Parameters:
- OPC_BR, 5'b10010, opcode (IR[31:27]) of the conditional-branch instruction.
- MEM_TIMEOUT, 15, max cycles Read is held in T1 waiting for mem_ack before fault (1..255).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin one instruction; sampled only in IDLE
- ir  in  32  IR register output
- con  in  1  condition flip-flop output
- mem_ack  in  1  memory read data valid into MDR this cycle
- PCout, MARin, IncPC, Zin, Zlowout, PCin  out  1 each  datapath strobes
- Read, MDRin, MDRout, IRin  out  1 each  memory/IR strobes
- Gra, Rout, CONin, Yin, Cout  out  1 each  branch-execute strobes
- alu_add  out  1  ALU operation select = ADD
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse: instruction completed
- illegal  out  1  one-cycle pulse: fetched opcode is not OPC_BR
- fault  out  1  one-cycle pulse: memory timeout
- taken_cnt  out  8  count of taken branches, wraps 255→0

Behaviour:
- Reset (async, reset_n=0): state=IDLE, wait counter=0, taken_cnt=0; all outputs 0 immediately.
- Strobes are decoded combinationally from the state register only; no strobe depends on a same-cycle input, except PCin in T6.
- States, strobes and transitions:
  - IDLE: none. start=1 → T0, otherwise stay.
  - T0: PCout, MARin, IncPC, Zin → T1.
  - T1: Zlowout, PCin (first T1 cycle only), Read, MDRin (every T1 cycle).
    - mem_ack=1 → T2.
    - Otherwise increment the wait counter. If the counter reaches MEM_TIMEOUT without mem_ack → FAULT.
  - T2: MDRout, IRin → DEC.
  - DEC: none. Evaluates ir[31:27].
    - == OPC_BR → T3.
    - Otherwise → ILL.
  - T3: Gra, Rout, CONin → T4.
  - T4: PCout, Yin → T5.
  - T5: Cout, alu_add, Zin → T6.
  - T6: Zlowout; PCin = con.
    - If con=1, taken_cnt increments on this edge.
    - → DONE.
  - DONE: done=1 → IDLE.
  - ILL: illegal=1 → IDLE.
  - FAULT: fault=1 → IDLE.
- Wait counter: 8-bit, cleared on entry to T1.
  - mem_ack on the first T1 cycle means zero wait cycles.
  - mem_ack arriving on the same cycle the counter hits MEM_TIMEOUT wins: go to T2, no fault.
- Latency: start to done pulse = 10 cycles, plus N extra T1 cycles for N wait cycles.
- start while busy is ignored, not queued.
- mem_ack outside T1 is ignored.
- con is ignored outside T6.
- reset_n low mid-instruction: immediate return to IDLE with all strobes 0; taken_cnt cleared.

Test Plan:
- Reset: hold reset_n=0 mid-T4 → all strobes 0, busy=0, taken_cnt=0 asynchronously; after release, IDLE with no spontaneous transitions.
- Taken branch, zero-wait memory:
  - Stimulus: start pulse, mem_ack=1 on the first T1 cycle, ir=32'h9080_0010 (opcode 10010), con=1.
  - Response: exact 10-cycle strobe sequence, PCin=1 in T6, done pulses in cycle 10, taken_cnt=1.
- Not-taken branch with 3 wait cycles:
  - Stimulus: mem_ack on the 4th T1 cycle, con=0.
  - Response: Read/MDRin high for 4 cycles, PCin low in T6, done at cycle 13, taken_cnt unchanged.
- Illegal opcode: ir[31:27]=5'b00011 → illegal pulses one cycle after DEC, busy drops, no T3 strobes, taken_cnt unchanged.
- Timeout: MEM_TIMEOUT=15, mem_ack held 0 → fault pulses, return to IDLE; repeat with mem_ack on the exact timeout cycle → T2, no fault.
- Wrap and ignored start:
  - 256 taken branches → taken_cnt returns to 0.
  - start asserted during T3 → no effect on the sequence and no extra instruction.
